// File: rtl/vga_tile_mem_arbiter.sv
`default_nettype none
// ============================================================================
// vga_tile_mem_arbiter: tile colour RAM sequencer (display > clear > host queue)
// Rev 1.0
// ============================================================================
module vga_tile_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 6,
  parameter int WQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        disp_req,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic                        disp_rvalid,
  output logic [DATA_W-1:0]           disp_rdata,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        clr_start,
  input  logic [DATA_W-1:0]           clr_color,
  output logic                        clr_busy,
  output logic [$clog2(WQ_DEPTH):0]   wq_count,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int c_PTR_W = $clog2(WQ_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [ADDR_W-1:0]  r_wq_addr [WQ_DEPTH];
  logic [DATA_W-1:0]  r_wq_data [WQ_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_clr_busy;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [DATA_W-1:0]  r_clr_color;
  logic               r_rd_p1;
  logic               r_rvalid;
  logic [DATA_W-1:0]  r_rdata;

  logic w_full, w_push, w_pop, w_gnt_disp, w_gnt_clr;

  // Full is taken from the registered count so a same-cycle pop never frees a slot
  assign w_full     = (r_count == c_CNT_W'(WQ_DEPTH));
  assign wr_ready   = !rst && !w_full;
  assign w_push     = wr_valid && wr_ready;
  assign w_gnt_disp = !rst && disp_req;
  assign w_gnt_clr  = !rst && !disp_req && r_clr_busy;
  assign w_pop      = !rst && !disp_req && !r_clr_busy && (r_count != '0);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_disp) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (w_gnt_clr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_clr_cnt;
      mem_wdata = r_clr_color;
    end else if (w_pop) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_wq_addr[r_rd_ptr];
      mem_wdata = r_wq_data[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wq_addr[r_wr_ptr] <= wr_addr;
      r_wq_data[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_clr_busy  <= 1'b0;
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
      r_rd_p1     <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (!r_clr_busy) begin
        if (clr_start) begin
          r_clr_busy  <= 1'b1;
          r_clr_cnt   <= '0;
          r_clr_color <= clr_color;
        end
      end else if (w_gnt_clr) begin
        if (r_clr_cnt == '1) r_clr_busy <= 1'b0;
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end

      // Two-stage read return: RAM data appears one cycle after the strobe
      r_rd_p1  <= w_gnt_disp;
      r_rvalid <= r_rd_p1;
      if (r_rd_p1) r_rdata <= mem_rdata;
    end
  end

  assign wq_count    = r_count;
  assign clr_busy    = r_clr_busy;
  assign disp_rvalid = r_rvalid;
  assign disp_rdata  = r_rdata;

endmodule
`default_nettype wire
